// File: rtl/memory_bist_pkg.sv
// Shared types and the reference data generator for the memory BIST engine.
// Pure package: no latency, no flow control.
// Holds the FSM state enum, the pattern/mode enum and the expected-data function.
package memory_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_READ     = 3'd2,
    ST_CMP      = 3'd3,
    ST_NEXT_PAT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_ZERO    = 2'd0,
    MODE_ADDR    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_ALL     = 2'd3
  } mode_e;

  // Last pattern index when cycling through all patterns in MODE_ALL.
  localparam logic [1:0]  LAST_PAT = 2'd2;
  localparam logic [15:0] ERR_MAX  = 16'hFFFF;

  // Expected memory word for a pattern at a given address, computed at the
  // widest legal data/address width (64 bits). Callers size the result to
  // DWIDTH and feed the address zero-extended from AWIDTH, which yields the
  // truncation / zero-extension behaviour of the address pattern for free.
  function automatic logic [63:0] expected_data(input logic [1:0]  pat,
                                                input logic [63:0] addr);
    logic [63:0] r;
    case (pat)
      MODE_ADDR:    r = addr;
      MODE_CHECKER: r = addr[0] ? {32{2'b10}} : {32{2'b01}};
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_bist_m.sv
// Memory built-in self test: writes a pattern over the whole array, reads it back and counts mismatches.
// Latency: 3*DEPTH cycles per pattern (+1 between patterns in MODE_ALL); start to busy is one cycle.
// Backpressure: none; the memory is assumed to accept one access per cycle, abort ends a run at any time.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          run request (sampled in idle) / cancel (priority over start)
//   mode, stop_on_error   pattern select and early-stop, latched with start
//   mem_addr/wdata/we/re  memory command, all registered; read data returns one cycle after mem_re
//   mem_rdata             memory read data
//   busy, done, pass      run status; pass valid while done
//   err_count             saturating mismatch count
//   fail_addr, fail_mode  address and pattern of the first mismatch
module memory_bist_m
  import memory_bist_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              stop_on_error,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [1:0]        fail_mode
);

  localparam logic [AWIDTH-1:0] ADDR_LAST = '1;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [1:0]          pat_q, pat_d;
  logic                stop_q, stop_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic [AWIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [1:0]          fail_mode_q, fail_mode_d;

  logic [DWIDTH-1:0]   cmp_exp;
  logic                mismatch;
  logic                go_done;

  // Read data in CMP belongs to the address presented during the preceding READ,
  // which addr_q still holds. Case inequality makes X/Z on the bus a failure.
  always_comb begin
    cmp_exp  = DWIDTH'(expected_data(pat_q, 64'(addr_q)));
    mismatch = (mem_rdata !== cmp_exp);
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pat_d       = pat_q;
    stop_d      = stop_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_mode_d = fail_mode_q;
    go_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode_e'(mode);
          stop_d      = stop_on_error;
          pat_d       = (mode == MODE_ALL) ? 2'(MODE_ZERO) : mode;
          addr_d      = '0;
          err_d       = '0;
          fail_addr_d = '0;
          fail_mode_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          we_d        = 1'b1;
          state_d     = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          re_d    = 1'b1;
          state_d = ST_READ;
        end else begin
          addr_d  = addr_q + 1'b1;
          we_d    = 1'b1;
        end
      end

      ST_READ: state_d = ST_CMP;

      ST_CMP: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 16'd1;
          if (err_q == 16'd0) begin
            fail_addr_d = addr_q;
            fail_mode_d = pat_q;
          end
        end
        if (mismatch && stop_q) begin
          go_done = 1'b1;
        end else if (addr_q != ADDR_LAST) begin
          addr_d  = addr_q + 1'b1;
          re_d    = 1'b1;
          state_d = ST_READ;
        end else if (mode_q == MODE_ALL && pat_q != LAST_PAT) begin
          state_d = ST_NEXT_PAT;
        end else begin
          // The final pattern finishes straight into DONE, so a single-pattern
          // run is busy for exactly 3*DEPTH cycles with no turnaround slot.
          go_done = 1'b1;
        end
      end

      ST_NEXT_PAT: begin
        pat_d   = pat_q + 2'd1;
        addr_d  = '0;
        we_d    = 1'b1;
        state_d = ST_WRITE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (go_done) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == 16'd0);
    end

    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      we_d    = 1'b0;
      re_d    = 1'b0;
    end

    // Write data is registered alongside the address it belongs to.
    wdata_d = we_d ? DWIDTH'(expected_data(pat_d, 64'(addr_d))) : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ZERO;
      pat_q       <= '0;
      stop_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_mode_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pat_q       <= pat_d;
      stop_q      <= stop_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_mode_q <= fail_mode_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_mode = fail_mode_q;

endmodule

// File: tb/tb_memory_bist_m.sv
// Synchronous single-port memory with a stuck-at fault on one address (applied on read).
// Latency: read data one cycle after re; writes land on the re/we edge.
// Backpressure: none.
module memory_sync_m #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic [DWIDTH-1:0] rdata,
  input  logic              fault_en,
  input  logic [AWIDTH-1:0] fault_addr,
  input  logic [DWIDTH-1:0] sa0_mask,
  input  logic [DWIDTH-1:0] sa1_mask
);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  always @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= (fault_en && addr == fault_addr) ? ((mem[addr] & ~sa0_mask) | sa1_mask) : mem[addr];
  end
endmodule

// Bench for memory_bist_m: directed table, hand sequences and random runs against a pattern-level model.
module tb_memory_bist_m;
  logic clk, rst_n, rst4_n;
  logic start, abort, stop_on_error;
  logic [1:0] mode;
  logic [4:0] mem_addr8, fa8, f_addr;
  logic [7:0] mem_wdata8, mem_rdata8, f_sa0, f_sa1;
  logic mem_we8, mem_re8, busy8, done8, pass8, f_en;
  logic [15:0] err8;
  logic [1:0] fm8;

  logic start4;
  logic [1:0] mode4;
  logic [5:0] mem_addr4, fa4;
  logic [3:0] mem_wdata4, mem_rdata4;
  logic mem_we4, mem_re4, busy4, done4, pass4;
  logic [15:0] err4;
  logic [1:0] fm4;

  int checks = 0;
  int errors = 0;
  int wl_a[$], wl_d[$];
  int rd_cnt8 = 0, ovl_cnt = 0;
  int wl4_a[$], wl4_d[$];
  int ovl4 = 0;
  int m_wa[$], m_wd[$];
  int m_busy, m_err, m_fa, m_fm, m_pass, m_reads;

  typedef struct {
    int mode; int stop; int fen; int faddr; int sa0; int sa1;
    int e_busy; int e_err; int e_fa; int e_fm; int e_pass; int e_writes;
  } vec_t;
  vec_t vecs[7];

  memory_bist_m #(.DWIDTH(8), .AWIDTH(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .stop_on_error(stop_on_error), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_we(mem_we8), .mem_re(mem_re8), .mem_rdata(mem_rdata8), .busy(busy8),
    .done(done8), .pass(pass8), .err_count(err8), .fail_addr(fa8), .fail_mode(fm8));

  memory_sync_m #(.DWIDTH(8), .AWIDTH(5)) u_mem (
    .clk(clk), .addr(mem_addr8), .wdata(mem_wdata8), .we(mem_we8), .re(mem_re8),
    .rdata(mem_rdata8), .fault_en(f_en), .fault_addr(f_addr), .sa0_mask(f_sa0), .sa1_mask(f_sa1));

  memory_bist_m #(.DWIDTH(4), .AWIDTH(6)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .abort(1'b0), .mode(mode4),
    .stop_on_error(1'b0), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_we(mem_we4), .mem_re(mem_re4), .mem_rdata(mem_rdata4), .busy(busy4),
    .done(done4), .pass(pass4), .err_count(err4), .fail_addr(fa4), .fail_mode(fm4));

  memory_sync_m #(.DWIDTH(4), .AWIDTH(6)) u_mem4 (
    .clk(clk), .addr(mem_addr4), .wdata(mem_wdata4), .we(mem_we4), .re(mem_re4),
    .rdata(mem_rdata4), .fault_en(1'b0), .fault_addr(6'd0), .sa0_mask(4'd0), .sa1_mask(4'd0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we8) begin wl_a.push_back(int'(mem_addr8)); wl_d.push_back(int'(mem_wdata8)); end
    if (mem_re8) rd_cnt8++;
    if (mem_we8 && mem_re8) ovl_cnt++;
    if (mem_we4) begin wl4_a.push_back(int'(mem_addr4)); wl4_d.push_back(int'(mem_wdata4)); end
    if (mem_we4 && mem_re4) ovl4++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pattern value from first principles: address pattern is addr mod 2^dw; the
  // checkerboard sets even bits on even addresses and odd bits on odd ones.
  function automatic int ref_exp(input int p, input int a, input int dw);
    int v = 0;
    if (p == 1) v = a % (1 << dw);
    else if (p == 2)
      for (int b = 0; b < dw; b++) if (((b % 2) == 0) != ((a % 2) == 1)) v += (1 << b);
    return v;
  endfunction

  // Whole-run model for the 8x32 instance: write every word, read every word,
  // track errors, honour early stop; busy = writes + 2*reads + pattern turnarounds.
  task automatic model8(input int m, input int s, input int fen, input int fa, input int sa0, input int sa1);
    int mem[32];
    int pats[$];
    bit stopped = 0;
    m_wa.delete(); m_wd.delete();
    m_busy = 0; m_err = 0; m_fa = 0; m_fm = 0; m_reads = 0;
    if (m == 3) pats = '{0, 1, 2}; else pats = '{m};
    for (int pi = 0; pi < pats.size() && !stopped; pi++) begin
      if (pi > 0) m_busy++;
      for (int a = 0; a < 32; a++) begin
        mem[a] = ref_exp(pats[pi], a, 8);
        m_wa.push_back(a); m_wd.push_back(mem[a]);
        m_busy++;
      end
      for (int a = 0; a < 32 && !stopped; a++) begin
        int rd = mem[a];
        if (fen != 0 && a == fa) rd = ((rd & ~sa0) | sa1) & 255;
        m_busy += 2; m_reads++;
        if (rd != ref_exp(pats[pi], a, 8)) begin
          if (m_err == 0) begin m_fa = a; m_fm = pats[pi]; end
          m_err++;
          if (s != 0) stopped = 1;
        end
      end
    end
    m_pass = (m_err == 0) ? 1 : 0;
  endtask

  task automatic do_run8(input int m, input int s, input int abort_at, input int restart_at,
                         output int bc, output int to);
    @(negedge clk);
    start = 1'b1; mode = 2'(m); stop_on_error = (s != 0);
    @(negedge clk);
    start = 1'b0;
    bc = 0; to = 1;
    for (int i = 0; i < 1000; i++) begin
      if (busy8) bc++;
      if (done8) begin to = 0; break; end
      if (i == abort_at) begin
        abort = 1'b1; @(negedge clk); abort = 1'b0; to = 0; break;
      end
      if (i == restart_at) begin start = 1'b1; mode = 2'd3; end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic cmp_model(input string tag, input int w_base, input int r_base);
    int diffs = 0;
    int n = wl_a.size() - w_base;
    check({tag, "_nwrites"}, n, m_wa.size());
    for (int k = 0; k < n && k < m_wa.size(); k++)
      if (wl_a[w_base + k] != m_wa[k] || wl_d[w_base + k] != m_wd[k]) diffs++;
    check({tag, "_wdiffs"}, diffs, 0);
    check({tag, "_nreads"}, rd_cnt8 - r_base, m_reads);
  endtask

  initial begin
    int bc, to, wb, rb, n5, cnt, diffs;
    int a5[$];
    vecs[0] = '{0, 0, 0, 0, 0,    0,    96,  0, 0,  0, 1, 32};
    vecs[1] = '{3, 0, 0, 0, 0,    0,    290, 0, 0,  0, 1, 96};
    vecs[2] = '{1, 0, 1, 7, 'h01, 0,    96,  1, 7,  1, 0, 32};
    vecs[3] = '{3, 1, 1, 3, 0,    'h80, 40,  1, 3,  0, 0, 32};
    vecs[4] = '{2, 0, 1, 4, 0,    'h01, 96,  0, 0,  0, 1, 32};
    vecs[5] = '{3, 0, 1, 31, 'hFF, 0,   290, 2, 31, 1, 0, 96};
    vecs[6] = '{2, 1, 1, 0, 'h01, 0,    34,  1, 0,  2, 0, 32};

    rst_n = 1'b0; rst4_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; stop_on_error = 1'b0;
    start4 = 1'b0; mode4 = 2'd0; f_en = 1'b0; f_addr = '0; f_sa0 = '0; f_sa1 = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {mem_addr8, mem_wdata8, mem_we8, mem_re8, busy8, done8, pass8, err8, fa8, fm8}, 64'd0);
    rst_n = 1'b1; rst4_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", {mem_we8, mem_re8, busy8, done8, pass8, err8}, 64'd0);

    for (int i = 0; i < 7; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      f_en = (vecs[i].fen != 0); f_addr = 5'(vecs[i].faddr);
      f_sa0 = 8'(vecs[i].sa0); f_sa1 = 8'(vecs[i].sa1);
      model8(vecs[i].mode, vecs[i].stop, vecs[i].fen, vecs[i].faddr, vecs[i].sa0, vecs[i].sa1);
      wb = wl_a.size(); rb = rd_cnt8;
      do_run8(vecs[i].mode, vecs[i].stop, -1, -1, bc, to);
      check({t, "_timeout"}, to, 0);
      check({t, "_busy_cycles"}, bc, vecs[i].e_busy);
      check({t, "_err_count"}, err8, vecs[i].e_err);
      check({t, "_fail_addr"}, fa8, vecs[i].e_fa);
      check({t, "_fail_mode"}, fm8, vecs[i].e_fm);
      check({t, "_pass"}, pass8, vecs[i].e_pass);
      check({t, "_writes"}, wl_a.size() - wb, vecs[i].e_writes);
      cmp_model(t, wb, rb);
      repeat (2) @(negedge clk);
      check({t, "_done_hold"}, {done8, busy8, pass8}, {1'b1, 1'b0, 1'(vecs[i].e_pass)});
    end

    // Mode 3 write data seen at address 5 over the three patterns.
    f_en = 1'b0;
    wb = wl_a.size();
    do_run8(3, 0, -1, -1, bc, to);
    for (int k = wb; k < wl_a.size(); k++) if (wl_a[k] == 5) a5.push_back(wl_d[k]);
    n5 = a5.size();
    check("addr5_nwrites", n5, 3);
    if (n5 == 3) begin
      check("addr5_p0", a5[0], 'h00);
      check("addr5_p1", a5[1], 'h05);
      check("addr5_p2", a5[2], 'hAA);
    end

    // Abort 40 cycles into a mode 0 run, then a clean run.
    do_run8(0, 0, 40, -1, bc, to);
    check("abort_status", {busy8, done8, mem_we8, mem_re8}, 4'b0000);
    repeat (2) @(negedge clk);
    check("abort_stays_idle", {busy8, done8}, 2'b00);
    do_run8(0, 0, -1, -1, bc, to);
    check("post_abort_busy", bc, 96);
    check("post_abort_pass", {done8, pass8, err8}, {2'b11, 16'd0});

    // A start while busy must not restart or change the mode.
    wb = wl_a.size();
    do_run8(0, 0, -1, 10, bc, to);
    check("restart_ignored_busy", bc, 96);
    check("restart_ignored_writes", wl_a.size() - wb, 32);

    for (int r = 0; r < 12; r++) begin
      int m, s, fe, fa, s0, s1;
      string t;
      t = $sformatf("rand%0d", r);
      m = $urandom_range(0, 3); s = $urandom_range(0, 1); fe = $urandom_range(0, 1);
      fa = $urandom_range(0, 31); s0 = $urandom & $urandom & 255; s1 = $urandom & $urandom & $urandom & 255;
      f_en = (fe != 0); f_addr = 5'(fa); f_sa0 = 8'(s0); f_sa1 = 8'(s1);
      model8(m, s, fe, fa, s0, s1);
      wb = wl_a.size(); rb = rd_cnt8;
      do_run8(m, s, -1, -1, bc, to);
      check({t, "_busy"}, bc, m_busy);
      check({t, "_result"}, {err8, 3'(fa8), 2'(fm8), pass8, done8}, {16'(m_err), 3'(m_fa), 2'(m_fm), 1'(m_pass), 1'b1});
      check({t, "_fail_addr"}, fa8, m_fa);
      cmp_model(t, wb, rb);
    end
    f_en = 1'b0;

    // 4-bit data, 64-word instance: address pattern wraps at 16.
    wb = wl4_a.size();
    @(negedge clk); start4 = 1'b1; mode4 = 2'd1;
    @(negedge clk); start4 = 1'b0;
    bc = 0; to = 1;
    for (int i = 0; i < 1000; i++) begin
      if (busy4) bc++;
      if (done4) begin to = 0; break; end
      @(negedge clk);
    end
    check("d4_timeout", to, 0);
    check("d4_busy", bc, 192);
    check("d4_pass", {pass4, err4}, {1'b1, 16'd0});
    cnt = wl4_a.size() - wb;
    check("d4_nwrites", cnt, 64);
    diffs = 0;
    for (int k = 0; k < cnt; k++)
      if (wl4_a[wb + k] != k || wl4_d[wb + k] != ref_exp(1, k, 4)) diffs++;
    check("d4_wdata", diffs, 0);

    // Reset pulse during a read: outputs clear without waiting for a clock.
    repeat (2) @(negedge clk);
    start4 = 1'b1; mode4 = 2'd1;
    @(negedge clk); start4 = 1'b0;
    to = 1;
    for (int i = 0; i < 500; i++) begin
      if (mem_re4) begin to = 0; break; end
      @(negedge clk);
    end
    check("d4_reached_read", to, 0);
    #2 rst4_n = 1'b0;
    #1;
    check("d4_async_reset", {mem_addr4, mem_wdata4, mem_we4, mem_re4, busy4, done4, pass4, err4, fa4, fm4}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    wb = wl4_a.size();
    rst4_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("d4_no_write_at_release", wl4_a.size() - wb, 0);
    check("d4_idle_after_reset", {busy4, done4, mem_we4, mem_re4}, 4'b0000);

    check("we_re_overlap8", ovl_cnt, 0);
    check("we_re_overlap4", ovl4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bist_m.md
MEMORY_BIST_M -- requirements
Module: memory_bist_m

Interface
REQ-001 Parameter DWIDTH, default 8, memory data width in bits (legal range 2..64).
REQ-002 Parameter AWIDTH, default 5, memory address width; DEPTH = 2**AWIDTH.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a test run; ignored while busy.
REQ-006 abort  input  1  terminate the current run and return to idle.
REQ-007 mode  input  2  pattern select, sampled with start: 0 clear-zero, 1 data=address, 2 checkerboard, 3 all three in order 0,1,2.
REQ-008 stop_on_error  input  1  sampled with start; end the run at the first mismatch.
REQ-009 mem_addr  output  AWIDTH  memory address.
REQ-010 mem_wdata  output  DWIDTH  memory write data.
REQ-011 mem_we  output  1  synchronous write strobe; memory writes mem_wdata at the clk edge where mem_we=1.
REQ-012 mem_re  output  1  read strobe; memory presents mem_rdata one cycle later.
REQ-013 mem_rdata  input  DWIDTH  memory read data.
REQ-014 busy  output  1  high while a run is in progress.
REQ-015 done  output  1  high from run completion until the next accepted start.
REQ-016 pass  output  1  valid while done; 1 when err_count is 0.
REQ-017 err_count  output  16  total mismatches in the run; saturates at 16'hFFFF.
REQ-018 fail_addr  output  AWIDTH  address of the first mismatch in the run.
REQ-019 fail_mode  output  2  pattern active at the first mismatch.

Function
REQ-020 FSM states: IDLE, WRITE, READ, CMP, NEXT_PAT, DONE.
REQ-021 IDLE + start: latch mode and stop_on_error, clear err_count/fail_addr/fail_mode/done, address counter = 0, go to WRITE; busy rises the following cycle.
REQ-022 WRITE: one write per cycle, addresses 0..DEPTH-1 ascending, mem_we=1, mem_wdata = expected(pattern, addr); after DEPTH-1, go to READ with address = 0.
REQ-023 READ: mem_re=1, mem_addr = address; go to CMP.
REQ-024 CMP: compare mem_rdata to expected(pattern, addr); a 4-state inequality (including X/Z) counts as a mismatch; increment the address and return to READ, or after DEPTH-1 go to NEXT_PAT.
REQ-025 Timing: each pattern takes exactly 3*DEPTH cycles (DEPTH write + 2*DEPTH read/compare); 96 cycles at default parameters.
REQ-026 NEXT_PAT: in mode 3, advance the pattern 0 to 1 to 2 and go to WRITE (1 cycle); otherwise go to DONE.
REQ-027 Expected data: pattern 0 = all zeros; pattern 1 = addr zero-extended or truncated to DWIDTH; pattern 2 = repeated 01 bit-pairs (LSB=1, 8'h55) for even addr and the bitwise inverse (8'hAA) for odd addr, truncated to DWIDTH.
REQ-028 On every mismatch, err_count += 1 (saturating); on the first mismatch only, capture fail_addr and fail_mode.
REQ-029 stop_on_error=1 and mismatch in CMP: go directly to DONE the next cycle, with no further reads.
REQ-030 DONE: busy=0, done=1, pass = (err_count==0); return to IDLE the next cycle, with done held.
REQ-031 abort in any non-IDLE state: go to IDLE next cycle, busy=0, done=0, mem_we=0, mem_re=0; abort has priority over start.
REQ-032 mem_we and mem_re are never high together; both are 0 outside WRITE and READ.
REQ-033 Address counter wraps only by explicit reset to 0 at phase change; it never advances past DEPTH-1.

Reset
REQ-034 rst_n low: state=IDLE; busy, done, pass, mem_we, mem_re = 0; mem_addr, mem_wdata, err_count, fail_addr, fail_mode = 0.
REQ-035 Reset mid-run takes effect immediately and asynchronously; no memory write may occur on the edge coinciding with reset deassertion.

Structure
REQ-036 Package memory_bist_pkg holds the state enum, the mode enum, and the expected-data function parametrised by DWIDTH/AWIDTH.
REQ-037 The RTL is a single module with no sub-module; the bench uses a synchronous memory model memory_sync_m with a stuck-bit fault-injection hook.

Verification
REQ-038 Defaults, mode 0, fault-free: busy exactly 96 cycles, done=1, pass=1, err_count=0.
REQ-039 Mode 3, fault-free: busy 3*96+2 cycles, pass=1; write data at addr 5 is 8'h00, 8'h05, 8'hAA in sequence.
REQ-040 Mode 1, bit 0 stuck-at-0 at addr 7: err_count=1, fail_addr=7, fail_mode=1, pass=0.
REQ-041 Mode 3, stop_on_error=1, addr 3 bit 7 stuck-at-1: run ends during pattern 0 at addr 3, err_count=1, no pattern-1 writes.
REQ-042 Abort at cycle 40 of mode 0: busy=0 and done=0 next cycle; a subsequent start runs cleanly to pass=1.
REQ-043 DWIDTH=4, AWIDTH=6, mode 1: expected data = addr[3:0]; rst_n pulsed low mid-READ sets all outputs to reset values immediately.
